// File: rtl/branch_resolve_ctrl_pkg.sv
// Shared types and constants for the branch resolve controller.
// Optional build macro: BRANCH_DELAY_SLOT_EN.
package branch_resolve_ctrl_pkg;

    typedef enum logic [2:0] {
        BR_OP_BEQ  = 3'b000,
        BR_OP_BNE  = 3'b001,
        BR_OP_BLTZ = 3'b010,
        BR_OP_BGTZ = 3'b011,
        BR_OP_BLEZ = 3'b100,
        BR_OP_BGEZ = 3'b101
    } br_op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_EVAL  = 2'd2,
        S_REDIR = 2'd3
    } state_e;

    localparam int unsigned PC_INC = 4;

    // Codes above BGEZ have no Compare function behind them.
    function automatic logic op_legal(input logic [2:0] op);
        return op <= BR_OP_BGEZ;
    endfunction

endpackage

// File: rtl/branch_resolve_ctrl_if.sv
// Decode-accept and fetch-redirect handshakes of the branch controller.
// Optional build macro: BRANCH_DELAY_SLOT_EN (not used here).
interface branch_resolve_ctrl_if #(
    parameter int PC_W  = 32,
    parameter int OFF_W = 16
);
    logic             br_valid;
    logic             br_ready;
    logic [2:0]       br_op;
    logic [PC_W-1:0]  br_pc;
    logic [OFF_W-1:0] br_off;
    logic             redirect_valid;
    logic             redirect_ready;
    logic [PC_W-1:0]  redirect_pc;

    modport master (
        output br_valid, br_op, br_pc, br_off,
        output redirect_ready,
        input  br_ready, redirect_valid, redirect_pc
    );

    modport slave (
        input  br_valid, br_op, br_pc, br_off,
        input  redirect_ready,
        output br_ready, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/branch_resolve_ctrl_target_adder.sv
// Branch target: pc + 4 + (sext(off) << 2), wrapping modulo 2^PC_W.
// Optional build macro: BRANCH_DELAY_SLOT_EN (not used here).
module branch_resolve_ctrl_target_adder
    import branch_resolve_ctrl_pkg::*;
#(
    parameter int PC_W  = 32,
    parameter int OFF_W = 16
) (
    input  logic [PC_W-1:0]  pc_i,
    input  logic [OFF_W-1:0] off_i,
    output logic [PC_W-1:0]  target_o
);
    logic [PC_W-1:0] off_ext;

    assign off_ext = {{(PC_W-OFF_W){off_i[OFF_W-1]}}, off_i};
    assign target_o = pc_i + PC_W'(PC_INC) + (off_ext << 2);
endmodule

// File: rtl/branch_resolve_ctrl.sv
// Sequences one conditional branch through the shared ID-stage Compare unit.
// Optional build macro: BRANCH_DELAY_SLOT_EN keeps flush low on redirect.
module branch_resolve_ctrl
    import branch_resolve_ctrl_pkg::*;
#(
    parameter int PC_W  = 32,
    parameter int OFF_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    branch_resolve_ctrl_if.slave bus,
    input  logic                 ops_ready_i,
    output logic [2:0]           cmp_func_o,
    input  logic                 cmp_result_i,
    output logic                 stall_o,
    output logic                 flush_o,
    input  logic                 kill_i,
    output logic                 br_err_o
);
`ifdef BRANCH_DELAY_SLOT_EN
    localparam logic FLUSH_ON_REDIR = 1'b0;
`else
    localparam logic FLUSH_ON_REDIR = 1'b1;
`endif

    state_e           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [OFF_W-1:0] off_q, off_d;
    logic [PC_W-1:0]  target;
    logic             ready, rvalid, flush, err, stall;
    logic [2:0]       func;

    branch_resolve_ctrl_target_adder #(
        .PC_W  (PC_W),
        .OFF_W (OFF_W)
    ) u_adder (
        .pc_i     (pc_q),
        .off_i    (off_q),
        .target_o (target)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            pc_q    <= '0;
            off_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            pc_q    <= pc_d;
            off_q   <= off_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        pc_d    = pc_q;
        off_d   = off_q;
        ready   = 1'b0;
        rvalid  = 1'b0;
        flush   = 1'b0;
        err     = 1'b0;
        stall   = 1'b0;
        func    = 3'b000;
        unique case (state_q)
            S_IDLE: begin
                ready = 1'b1;
                if (bus.br_valid) begin
                    op_d    = bus.br_op;
                    pc_d    = bus.br_pc;
                    off_d   = bus.br_off;
                    state_d = ops_ready_i ? S_EVAL : S_WAIT;
                end
            end
            S_WAIT: begin
                stall = 1'b1;
                func  = op_q;
                if (ops_ready_i) state_d = S_EVAL;
            end
            S_EVAL: begin
                stall   = 1'b1;
                func    = op_q;
                state_d = S_IDLE;
                if (!op_legal(op_q)) err = 1'b1;
                else if (cmp_result_i) state_d = S_REDIR;
            end
            S_REDIR: begin
                stall  = 1'b1;
                func   = op_q;
                rvalid = 1'b1;
                if (bus.redirect_ready) begin
                    flush   = FLUSH_ON_REDIR;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Abort wins: nothing is accepted or transferred this cycle.
        if (kill_i || rst) begin
            state_d = S_IDLE;
            op_d    = op_q;
            pc_d    = pc_q;
            off_d   = off_q;
            ready   = 1'b0;
            rvalid  = 1'b0;
            flush   = 1'b0;
            err     = 1'b0;
        end
    end

    assign bus.br_ready       = ready;
    assign bus.redirect_valid = rvalid;
    assign bus.redirect_pc    = rvalid ? target : '0;
    assign cmp_func_o         = func;
    assign stall_o            = stall;
    assign flush_o            = flush;
    assign br_err_o           = err;
endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed, table-driven bench for branch_resolve_ctrl.
// Optional build macro: BRANCH_DELAY_SLOT_EN flips the expected flush.
module tb_branch_resolve_ctrl;
`ifdef BRANCH_DELAY_SLOT_EN
    localparam logic FLUSH_EXP = 1'b0;
`else
    localparam logic FLUSH_EXP = 1'b1;
`endif

    typedef struct {
        logic [2:0]  op;
        logic [31:0] pc;
        logic [15:0] off;
        int          w;
        logic        cmp;
        int          r;
        logic        taken;
        logic [31:0] tgt;
        logic        err;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       ops_ready, cmp_result, kill;
    logic [2:0] cmp_func;
    logic       stall, flush, br_err;
    int         nchk = 0;
    int         nerr = 0;
    vec_t       vecs[8];

    branch_resolve_ctrl_if #(.PC_W(32), .OFF_W(16)) bus();

    branch_resolve_ctrl #(.PC_W(32), .OFF_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .ops_ready_i  (ops_ready),
        .cmp_func_o   (cmp_func),
        .cmp_result_i (cmp_result),
        .stall_o      (stall),
        .flush_o      (flush),
        .kill_i       (kill),
        .br_err_o     (br_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        @(negedge clk);
        chk({tag, "_ready"}, 32'(bus.br_ready), 1);
        chk({tag, "_stall"}, 32'(stall), 0);
        chk({tag, "_rvalid"}, 32'(bus.redirect_valid), 0);
        chk({tag, "_func"}, 32'(cmp_func), 0);
    endtask

    task automatic drive_br(input logic [2:0] op, input logic [31:0] pc,
                            input logic [15:0] off, input logic ops,
                            input logic cmp);
        bus.br_valid = 1'b1;
        bus.br_op    = op;
        bus.br_pc    = pc;
        bus.br_off   = off;
        ops_ready    = ops;
        cmp_result   = cmp;
    endtask

    task automatic run_vec(input int k, input vec_t v);
        string t;
        t = $sformatf("v%0d", k);
        drive_br(v.op, v.pc, v.off, v.w == 0, v.cmp);
        bus.redirect_ready = 1'b0;
        @(negedge clk);
        chk({t, "_acc_ready"}, 32'(bus.br_ready), 1);
        chk({t, "_acc_stall"}, 32'(stall), 0);
        tick();
        bus.br_valid = 1'b0;
        for (int i = 0; i < v.w; i++) begin
            ops_ready = (i == v.w - 1);
            @(negedge clk);
            chk($sformatf("%s_wait%0d_stall", t, i), 32'(stall), 1);
            chk($sformatf("%s_wait%0d_func", t, i), 32'(cmp_func), 32'(v.op));
            chk($sformatf("%s_wait%0d_ready", t, i), 32'(bus.br_ready), 0);
            tick();
        end
        @(negedge clk);
        chk({t, "_eval_stall"}, 32'(stall), 1);
        chk({t, "_eval_func"}, 32'(cmp_func), 32'(v.op));
        chk({t, "_eval_err"}, 32'(br_err), 32'(v.err));
        chk({t, "_eval_rvalid"}, 32'(bus.redirect_valid), 0);
        tick();
        if (v.taken) begin
            for (int i = 0; i <= v.r; i++) begin
                bus.redirect_ready = (i == v.r);
                @(negedge clk);
                chk($sformatf("%s_rd%0d_rvalid", t, i),
                    32'(bus.redirect_valid), 1);
                chk($sformatf("%s_rd%0d_pc", t, i), bus.redirect_pc, v.tgt);
                chk($sformatf("%s_rd%0d_stall", t, i), 32'(stall), 1);
                chk($sformatf("%s_rd%0d_flush", t, i), 32'(flush),
                    (i == v.r) ? 32'(FLUSH_EXP) : 0);
                tick();
            end
            bus.redirect_ready = 1'b0;
        end
        @(negedge clk);
        chk({t, "_post_ready"}, 32'(bus.br_ready), 1);
        chk({t, "_post_stall"}, 32'(stall), 0);
        chk({t, "_post_err"}, 32'(br_err), 0);
        chk({t, "_post_flush"}, 32'(flush), 0);
        tick();
    endtask

    initial begin
        vecs[0] = '{3'b000, 32'h0040_0000, 16'h0003, 0, 1'b1, 0,
                    1'b1, 32'h0040_0010, 1'b0};
        vecs[1] = '{3'b001, 32'h0000_1000, 16'h0010, 0, 1'b0, 0,
                    1'b0, 32'h0, 1'b0};
        vecs[2] = '{3'b101, 32'h0000_2000, 16'hFFFF, 5, 1'b1, 0,
                    1'b1, 32'h0000_2000, 1'b0};
        vecs[3] = '{3'b010, 32'h0000_0010, 16'h8000, 0, 1'b1, 3,
                    1'b1, 32'hFFFE_0014, 1'b0};
        vecs[4] = '{3'b111, 32'h0000_3000, 16'h0001, 0, 1'b1, 0,
                    1'b0, 32'h0, 1'b1};
        vecs[5] = '{3'b011, 32'hFFFF_FFF8, 16'h0001, 1, 1'b1, 1,
                    1'b1, 32'h0000_0000, 1'b0};
        vecs[6] = '{3'b100, 32'h0000_0100, 16'h7FFF, 2, 1'b0, 0,
                    1'b0, 32'h0, 1'b0};
        vecs[7] = '{3'b110, 32'h0000_4000, 16'h0002, 0, 1'b0, 0,
                    1'b0, 32'h0, 1'b1};

        rst = 1'b1;
        kill = 1'b0;
        ops_ready = 1'b0;
        cmp_result = 1'b0;
        bus.br_valid = 1'b0;
        bus.br_op = 3'b000;
        bus.br_pc = '0;
        bus.br_off = '0;
        bus.redirect_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk_idle("reset");
        chk("reset_flush", 32'(flush), 0);
        chk("reset_err", 32'(br_err), 0);
        chk("reset_rpc", bus.redirect_pc, 0);
        tick();

        for (int k = 0; k < 8; k++) run_vec(k, vecs[k]);

        // kill in REDIRECT while fetch is ready: no transfer
        drive_br(3'b000, 32'h0040_0000, 16'h0003, 1'b1, 1'b1);
        tick();
        bus.br_valid = 1'b0;
        tick();
        bus.redirect_ready = 1'b1;
        kill = 1'b1;
        @(negedge clk);
        chk("killrd_rvalid", 32'(bus.redirect_valid), 0);
        chk("killrd_flush", 32'(flush), 0);
        tick();
        kill = 1'b0;
        bus.redirect_ready = 1'b0;
        chk_idle("killrd_after");
        tick();

        // kill in IDLE blocks acceptance
        drive_br(3'b000, 32'h0000_0100, 16'h0001, 1'b1, 1'b1);
        kill = 1'b1;
        @(negedge clk);
        chk("killidle_ready", 32'(bus.br_ready), 0);
        tick();
        kill = 1'b0;
        bus.br_valid = 1'b0;
        chk_idle("killidle_after");
        tick();

        // kill in EVAL of an illegal op suppresses br_err
        drive_br(3'b111, 32'h0000_0200, 16'h0001, 1'b1, 1'b0);
        tick();
        bus.br_valid = 1'b0;
        kill = 1'b1;
        @(negedge clk);
        chk("killeval_err", 32'(br_err), 0);
        tick();
        kill = 1'b0;
        chk_idle("killeval_after");
        tick();

        // reset while waiting for operands
        drive_br(3'b101, 32'h0000_0300, 16'h0004, 1'b0, 1'b1);
        tick();
        bus.br_valid = 1'b0;
        @(negedge clk);
        chk("rstmid_wait_stall", 32'(stall), 1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_idle("rstmid_after");
        tick();

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
